// File: rtl/bin2bcd_seq_ctrl.sv
// Sequential double-dabble binary-to-BCD converter with a start/busy/done handshake.
// Optional leading-zero blanking output is enabled by defining BIN2BCD_BLANK_EN.
module bin2bcd_seq_ctrl #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
`ifdef BIN2BCD_BLANK_EN
  output logic [DIGITS-1:0]     blank,
`endif
  output logic                  overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [4*DIGITS-1:0] r_work, w_work_nxt;
  logic [WIDTH-1:0]    r_op, w_op_nxt;
  logic                r_sticky, w_sticky_nxt;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;

  logic [4*DIGITS-1:0] w_added;
  logic [4*DIGITS-1:0] w_shift_bcd;
  logic [WIDTH-1:0]    w_shift_op;
  logic                w_shift_out;
  logic                w_last_shift;
  logic [DIGITS-1:0]   w_blank;

  logic                r_busy, r_done, r_overflow;
  logic [4*DIGITS-1:0] r_bcd;
  logic [DIGITS-1:0]   r_blank;

  function automatic logic [3:0] add3(input logic [3:0] n);
    logic [3:0] r;
    if (n <= 4'd4) begin
      r = n;
    end else if (n <= 4'd9) begin
      r = n + 4'd3;
    end else begin
      r = 4'd0;
    end
    return r;
  endfunction

  // Add-3 correction bank applied to every working nibble
  always_comb begin
    w_added = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_added[4*i +: 4] = add3(r_work[4*i +: 4]);
    end
  end

  assign {w_shift_out, w_shift_bcd, w_shift_op} = {r_work, r_op, 1'b0};
  assign w_last_shift = (r_state == S_SHIFT) && (r_cnt == CW'(1));

  // Leading-zero flags of the value about to be published; digit 0 never blanks
  always_comb begin
    logic zero_above;
    w_blank    = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (w_shift_bcd[4*i +: 4] == 4'd0);
      w_blank[i] = zero_above;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt  = r_state;
    w_work_nxt   = r_work;
    w_op_nxt     = r_op;
    w_sticky_nxt = r_sticky;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt  = S_ADD;
          w_op_nxt     = bin;
          w_work_nxt   = '0;
          w_sticky_nxt = 1'b0;
          w_cnt_nxt    = CW'(WIDTH);
        end else begin
          w_state_nxt  = S_IDLE;
        end
      end
      S_ADD: begin
        w_work_nxt  = w_added;
        w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        w_work_nxt   = w_shift_bcd;
        w_op_nxt     = w_shift_op;
        w_sticky_nxt = r_sticky | w_shift_out;
        w_cnt_nxt    = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_ADD;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and working registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_work   <= '0;
      r_op     <= '0;
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_work   <= w_work_nxt;
      r_op     <= w_op_nxt;
      r_sticky <= w_sticky_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  // Registered outputs, loaded on the edge that enters DONE so they are valid with done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
      r_blank    <= '0;
    end else begin
      r_busy <= (w_state_nxt == S_ADD) || (w_state_nxt == S_SHIFT);
      r_done <= w_last_shift;
      if (w_last_shift) begin
        r_bcd      <= w_shift_bcd;
        r_overflow <= r_sticky | w_shift_out;
        r_blank    <= w_blank;
      end else begin
        r_bcd      <= r_bcd;
        r_overflow <= r_overflow;
        r_blank    <= r_blank;
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign bcd      = r_bcd;
  assign overflow = r_overflow;
`ifdef BIN2BCD_BLANK_EN
  assign blank    = r_blank;
`else
  logic w_blank_unused;
  assign w_blank_unused = ^r_blank;
`endif

endmodule

// File: doc/bin2bcd_seq_ctrl.md
Name: bin2bcd_seq_ctrl

Overview:
- Sequential binary-to-BCD converter controller using the double-dabble (shift-and-add-3) algorithm.
- Owns a shift register of DIGITS BCD nibbles plus the binary operand.
- Time-multiplexes a bank of DIGITS add-3 correction cells (one per nibble) over WIDTH iterations.
- Feeds the seven-segment display path; accepts one conversion at a time via a start/busy/done handshake.

Parameters:
- WIDTH, 14, binary operand width in bits (>=1).
- DIGITS, 4, number of BCD output digits (>=1).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- bin  input  WIDTH  binary operand; captured on the accepting edge only.
- busy  output  1  high while a conversion is in progress (ADD/SHIFT states).
- done  output  1  one-cycle pulse; bcd/overflow valid and updated in that cycle.
- bcd  output  4*DIGITS  packed result, digit 0 in [3:0]; held until the next done.
- overflow  output  1  high if bin > 10^DIGITS-1; updated with bcd.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, bcd=0, overflow=0; internal shift register and counter cleared. Any conversion in progress is abandoned; no done is issued.
- States: IDLE, ADD, SHIFT, DONE. All outputs are registered.
- IDLE:
  - start=1 at edge E0 loads bin into the operand register, clears the working BCD register and sticky overflow, sets iteration counter=WIDTH, and moves to ADD.
  - start=0: remain in IDLE.
- ADD (one cycle): every working nibble is replaced by its add-3 correction (0-4 unchanged; 5-9 -> +3; 10-15 -> 0, unreachable in correct operation). Then go to SHIFT.
- SHIFT (one cycle):
  - The {BCD register, operand register} concatenation shifts left by 1 with LSB fill 0.
  - The bit leaving the MSB of the BCD register ORs into sticky overflow.
  - Counter decrements. If the counter becomes 0, go to DONE; else go to ADD.
- DONE (one cycle): bcd <= working register, overflow <= sticky flag, done=1, busy=0. Then go to IDLE.
- Latency:
  - done is high in the cycle following edge E0+2*WIDTH (28 edges for the defaults).
  - Minimum start-to-start spacing is 2*WIDTH+2 cycles.
- busy: 1 in ADD and SHIFT only; 0 in IDLE and DONE.
- start asserted in ADD, SHIFT or DONE is ignored, not queued. Changes on bin after E0 have no effect.
- Overflow result: bcd holds the low DIGITS decimal digits of bin (bin mod 10^DIGITS), and overflow=1.
- Counter width: clog2(WIDTH+1).

Optional Feature:
- Macro: BIN2BCD_BLANK_EN.
- Defined:
  - Adds output port blank (DIGITS bits), updated with bcd in DONE and reset to 0.
  - blank[i]=1 when digit i and all higher digits are 0, for i>=1.
  - blank[0] is always 0, so a value of 0 displays "0".
  - Used by the display driver to suppress leading zeros.
- Undefined: port absent; no blanking logic synthesized; all other behaviour identical.

Test Plan:
- rst pulse, then bin=0, start=1 for one cycle -> busy high for 28 cycles; done pulses on cycle 29 after start; bcd=16'h0000, overflow=0; with BLANK_EN, blank=4'b1110.
- bin=1234 -> bcd=16'h1234, overflow=0; bin=9999 -> bcd=16'h9999, overflow=0; with BLANK_EN, blank=4'b0000 for both.
- bin=10000 -> bcd=16'h0000, overflow=1; bin=16383 -> bcd=16'h6383, overflow=1.
- Start bin=42. Pulse start with bin=7 at cycle 10 and in the DONE cycle -> both ignored. Exactly one done; bcd=16'h0042; with BLANK_EN, blank=4'b1100.
- Start bin=5678; assert rst asynchronously mid-cycle at cycle 15 -> busy, done, bcd, overflow go to 0 immediately; no done follows. A new start with bin=5678 then yields bcd=16'h5678.
- Back-to-back: start bin=321 and, on done, assert start in the next cycle (IDLE) with bin=9000 -> second done after 2*WIDTH+1 edges with bcd=16'h9000. bcd holds 16'h0321 until then.
